// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: operand sequencer in front of an iterative unsigned divider.
// Buffers dividend/divisor pairs in a small FIFO and drives the divider through
// a clear / issue / wait sequence. Results are held on a valid/ready port.
// Divide-by-zero is answered locally. A watchdog aborts a divider that never
// answers.
module div_issue_ctrl #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TMO   = 4 * WIDTH + 8
) (
   input  logic             clk,
   input  logic             rst,
   // operand producer
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   // divider pins
   output logic [WIDTH-1:0] div_a,
   output logic [WIDTH-1:0] div_b,
   output logic             div_en,
   output logic             div_rst,
   input  logic             div_valid,
   input  logic [WIDTH-1:0] div_q,
   input  logic [WIDTH-1:0] div_r,
   // result consumer
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_q,
   output logic [WIDTH-1:0] out_r,
   output logic             out_dbz,
   output logic             out_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = $clog2(TMO + 1);

   typedef enum logic [2:0] {
      StIdle,
      StClr,
      StIssue,
      StWait,
      StOut
   } state_e;

   state_e             state_q;

   // Operand register between FIFO head and divider. op_vld_q marks a popped
   // pair that IDLE has not yet dispatched.
   logic [WIDTH-1:0]   op_a_q;
   logic [WIDTH-1:0]   op_b_q;
   logic               op_vld_q;
   logic [TW-1:0]      wd_q;

   // ------------------------------------------------------------------------
   // Input FIFO
   // ------------------------------------------------------------------------
   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [CW-1:0]      cnt_q;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [2*WIDTH-1:0] head;

   assign full     = (cnt_q == CW'(DEPTH));
   assign empty    = (cnt_q == '0);
   assign in_ready = !full;
   assign push     = in_valid && in_ready;
   // Only pop while IDLE has no pair already waiting for dispatch.
   assign pop      = (state_q == StIdle) && !op_vld_q && !empty;
   assign head     = mem_q[rd_ptr_q];

   // FIFO storage, written on accepted pushes; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_a, in_b};
      end
   end

   // FIFO pointers and occupancy; DEPTH is a power of two so pointers wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Sequencer FSM with registered divider and result outputs
   // ------------------------------------------------------------------------
   // div_en/div_rst default low each cycle so each is a one-cycle pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         op_a_q    <= '0;
         op_b_q    <= '0;
         op_vld_q  <= 1'b0;
         wd_q      <= '0;
         div_a     <= '0;
         div_b     <= '0;
         div_en    <= 1'b0;
         div_rst   <= 1'b0;
         out_valid <= 1'b0;
         out_q     <= '0;
         out_r     <= '0;
         out_dbz   <= 1'b0;
         out_err   <= 1'b0;
      end else begin
         div_en  <= 1'b0;
         div_rst <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (op_vld_q) begin
                  op_vld_q <= 1'b0;
                  if (op_b_q == '0) begin
                     // Divide-by-zero never reaches the divider.
                     state_q   <= StOut;
                     out_valid <= 1'b1;
                     out_q     <= '1;
                     out_r     <= op_a_q;
                     out_dbz   <= 1'b1;
                     out_err   <= 1'b0;
                  end else begin
                     state_q <= StClr;
                     div_rst <= 1'b1;
                     div_a   <= op_a_q;
                     div_b   <= op_b_q;
                  end
               end else if (pop) begin
                  op_a_q   <= head[2*WIDTH-1:WIDTH];
                  op_b_q   <= head[WIDTH-1:0];
                  op_vld_q <= 1'b1;
               end
            end
            StClr: begin
               state_q <= StIssue;
               div_en  <= 1'b1;
            end
            StIssue: begin
               state_q <= StWait;
               wd_q    <= '0;
            end
            StWait: begin
               if (div_valid) begin
                  state_q   <= StOut;
                  out_valid <= 1'b1;
                  out_q     <= div_q;
                  out_r     <= div_r;
                  out_dbz   <= 1'b0;
                  out_err   <= 1'b0;
                  div_a     <= '0;
                  div_b     <= '0;
                  wd_q      <= '0;
               end else if (wd_q == TW'(TMO - 1)) begin
                  // TMO cycles spent in WAIT without an answer: abort.
                  state_q   <= StOut;
                  out_valid <= 1'b1;
                  out_q     <= '0;
                  out_r     <= '0;
                  out_dbz   <= 1'b0;
                  out_err   <= 1'b1;
                  div_a     <= '0;
                  div_b     <= '0;
                  wd_q      <= '0;
               end else begin
                  wd_q <= wd_q + TW'(1);
               end
            end
            StOut: begin
               if (out_ready) begin
                  state_q   <= StIdle;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Self-checking bench for div_issue_ctrl with a behavioural divider model.
module tb_div_issue_ctrl;

   localparam int unsigned W   = 4;
   localparam int unsigned TMO = 4 * W + 8;
   localparam int unsigned LAT = W + 2;

   typedef struct packed {
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         err;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic [W-1:0] div_a;
   logic [W-1:0] div_b;
   logic         div_en;
   logic         div_rst;
   logic         div_valid;
   logic [W-1:0] div_q;
   logic [W-1:0] div_r;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_q;
   logic [W-1:0] out_r;
   logic         out_dbz;
   logic         out_err;

   int n_vec = 0;
   int n_err = 0;
   int en_cnt = 0;
   int rst_cnt = 0;
   exp_t exp_q[$];

   // divider model controls
   logic         dead = 1'b0;
   logic         stray = 1'b0;
   logic         busy;
   logic [7:0]   lat_cnt;
   logic         dv;
   logic [W-1:0] mq;
   logic [W-1:0] mr;

   always #5 clk = ~clk;

   div_issue_ctrl #(.WIDTH(W), .DEPTH(4), .TMO(TMO)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_en    (div_en),
      .div_rst   (div_rst),
      .div_valid (div_valid),
      .div_q     (div_q),
      .div_r     (div_r),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_q     (out_q),
      .out_r     (out_r),
      .out_dbz   (out_dbz),
      .out_err   (out_err)
   );

   // Divider model: clears on rst or parked divisor, answers LAT cycles after en.
   always @(posedge clk) begin
      dv <= 1'b0;
      if (div_rst || div_b == '0) begin
         busy <= 1'b0;
      end else if (div_en) begin
         busy    <= 1'b1;
         lat_cnt <= 8'(LAT);
         mq      <= div_a / div_b;
         mr      <= div_a % div_b;
      end else if (busy) begin
         if (lat_cnt == 0) begin
            busy <= 1'b0;
            dv   <= !dead;
         end else begin
            lat_cnt <= lat_cnt - 8'd1;
         end
      end
   end

   assign div_valid = dv | stray;
   assign div_q     = stray ? 4'h5 : mq;
   assign div_r     = stray ? 4'h6 : mr;

   initial begin
      busy    = 1'b0;
      dv      = 1'b0;
      lat_cnt = '0;
      mq      = '0;
      mr      = '0;
   end

   // pulse counters sampled mid-cycle
   always @(negedge clk) begin
      if (div_en) en_cnt++;
      if (div_rst) rst_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      if (b == '0) begin
         e.q = '1; e.r = a; e.dbz = 1'b1; e.err = 1'b0;
      end else begin
         e.q = a / b; e.r = a % b; e.dbz = 1'b0; e.err = 1'b0;
      end
      return e;
   endfunction

   // Offer a pair (called at a negedge); returns at the negedge after acceptance.
   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit abort);
      exp_t e;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      for (int i = 0; i < 400; i++) begin
         if (in_ready) begin
            if (abort) e = '{q: '0, r: '0, dbz: 1'b0, err: 1'b1};
            else       e = ref_div(a, b);
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
            return;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("push_timeout", 32'(in_ready), 1);
   endtask

   task automatic wait_en();
      for (int i = 0; i < 20; i++) begin
         if (div_en) return;
         @(negedge clk);
      end
      chk("wait_en_timeout", 32'(div_en), 1);
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      chk("drain_empty", 32'(exp_q.size()), 0);
   endtask

   // Scoreboard: pop expected result on every output handshake.
   always begin
      exp_t e;
      @(negedge clk);
      #1;
      if (rst && out_valid && out_ready) begin
         chk("out_expected", 32'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_q", 32'(out_q), 32'(e.q));
            chk("out_r", 32'(out_r), 32'(e.r));
            chk("out_dbz", 32'(out_dbz), 32'(e.dbz));
            chk("out_err", 32'(out_err), 32'(e.err));
         end
      end
   end

   initial begin
      int   n;
      int   en0;
      int   rst0;
      logic saw_ready;

      // ---- reset values
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_qr", 32'({out_q, out_r, out_dbz, out_err}), 0);
      chk("rst_div_pins", 32'({div_a, div_b, div_en, div_rst}), 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ---- directed 13/4 with exact sequencing
      en0  = en_cnt;
      rst0 = rst_cnt;
      push(4'd13, 4'd4, 1'b0);
      @(negedge clk);
      chk("t1_no_rst_yet", 32'(div_rst), 0);
      @(negedge clk);
      chk("clr_rst", 32'({div_rst, div_en}), 32'b10);
      chk("clr_ab", 32'({div_a, div_b}), 32'h d4);
      @(negedge clk);
      chk("issue_en", 32'({div_rst, div_en}), 32'b01);
      @(negedge clk);
      chk("wait_en_low", 32'(div_en), 0);
      chk("wait_b_held", 32'(div_b), 4);
      drain(60);
      chk("one_en_pulse", 32'(en_cnt - en0), 1);
      chk("one_rst_pulse", 32'(rst_cnt - rst0), 1);

      // ---- divide by zero
      en0  = en_cnt;
      rst0 = rst_cnt;
      push(4'd7, 4'd0, 1'b0);
      @(negedge clk);
      chk("dbz_t1_not_valid", 32'(out_valid), 0);
      @(negedge clk);
      chk("dbz_t2_valid", 32'(out_valid), 1);
      chk("dbz_result", 32'({out_q, out_r, out_dbz, out_err}), 32'({4'hF, 4'd7, 2'b10}));
      drain(20);
      chk("dbz_no_pulses", 32'((en_cnt - en0) + (rst_cnt - rst0)), 0);

      // ---- backpressure
      out_ready = 1'b0;
      push(4'd15, 4'd1, 1'b0);
      push(4'd15, 4'd15, 1'b0);
      push(4'd0, 4'd3, 1'b0);
      push(4'd9, 4'd2, 1'b0);
      push(4'd8, 4'd8, 1'b0);
      chk("bp_full", 32'(in_ready), 0);
      in_valid  = 1'b1;
      in_a      = 4'd2;
      in_b      = 4'd1;
      saw_ready = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (in_ready) saw_ready = 1'b1;
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk("bp_6th_blocked", 32'(saw_ready), 0);
      chk("bp_first_held", 32'({out_valid, out_q, out_r}), 32'({1'b1, 4'd15, 4'd0}));
      out_ready = 1'b1;
      drain(400);

      // ---- stray div_valid while in OUT
      out_ready = 1'b0;
      en0 = en_cnt;
      push(4'd10, 4'd3, 1'b0);
      for (int i = 0; i < 60; i++) begin
         if (out_valid) break;
         @(negedge clk);
      end
      chk("stray_out_reached", 32'(out_valid), 1);
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (2) @(negedge clk);
      chk("stray_out_hold", 32'({out_valid, out_q, out_r, out_dbz, out_err}),
          32'({1'b1, 4'd3, 4'd1, 2'b00}));
      chk("stray_out_no_issue", 32'(en_cnt - en0), 1);
      out_ready = 1'b1;
      drain(20);

      // ---- stray div_valid while IDLE
      repeat (3) @(negedge clk);
      en0  = en_cnt;
      rst0 = rst_cnt;
      stray = 1'b1;
      @(negedge clk);
      stray = 1'b0;
      repeat (3) @(negedge clk);
      chk("stray_idle_no_out", 32'(out_valid), 0);
      chk("stray_idle_no_pulse", 32'((en_cnt - en0) + (rst_cnt - rst0)), 0);
      chk("stray_idle_b", 32'(div_b), 0);

      // ---- reset mid-WAIT with two entries queued
      push(4'd14, 4'd3, 1'b0);
      push(4'd5, 4'd2, 1'b0);
      push(4'd12, 4'd4, 1'b0);
      wait_en();
      @(negedge clk);
      chk("mid_wait_b", 32'(div_b), 3);
      #2 rst = 1'b0;
      #1;
      exp_q.delete();
      chk("mr_in_ready", 32'(in_ready), 1);
      chk("mr_out", 32'({out_valid, out_q, out_r, out_dbz, out_err}), 0);
      chk("mr_div_pins", 32'({div_a, div_b, div_en, div_rst}), 0);
      @(negedge clk);
      rst = 1'b1;
      saw_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (out_valid || div_b != '0) saw_ready = 1'b1;
      end
      chk("mr_after_quiet", 32'(saw_ready), 0);
      chk("mr_after_ready", 32'(in_ready), 1);

      // ---- watchdog with a dead divider
      dead = 1'b1;
      push(4'd9, 4'd3, 1'b1);
      wait_en();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
      end
      chk("wd_latency", 32'(n), 32'(TMO + 1));
      drain(10);
      dead = 1'b0;
      push(4'd9, 4'd3, 1'b0);
      drain(60);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      $display("FAIL global_timeout: observed running, expected finished");
      $fatal(1, "bench timeout");
   end

endmodule
